// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - execute-stage issue/wait/capture controller for the iterative mult/div unit
module multdiv_issue_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            stage_advance,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            illegal_op,
  output logic            timeout_err,
  output logic            unit_valid,
  output logic [3:0]      unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  output logic            unit_flush,
  input  logic            unit_ok,
  input  logic [XLEN-1:0] unit_c
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state;
  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;
  logic           wd_fire;

  // Watchdog expiry is visible in the expiring WAIT cycle itself so the unit is cancelled at once.
  assign wd_fire     = ~reset & ~flush & ~unit_ok & (state == S_WAIT) &
                       (wd_cnt == WDW'(TIMEOUT - 1));
  assign timeout_err = timeout_q | wd_fire;
  assign unit_flush  = (~reset & flush & ((state == S_ISSUE) | (state == S_WAIT))) | wd_fire;
  assign stall       = req_valid & ~result_valid & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wd_cnt       <= '0;
      timeout_q    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      unit_valid   <= 1'b0;
      unit_op      <= '0;
      unit_a       <= '0;
      unit_b       <= '0;
    end else begin
      unit_valid <= 1'b0;
      if (flush) begin
        state        <= S_IDLE;
        result       <= '0;
        result_valid <= 1'b0;
        illegal_op   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              if (req_op <= 4'd9) begin
                unit_op    <= req_op;
                unit_a     <= req_a;
                unit_b     <= req_b;
                unit_valid <= 1'b1;
                state      <= S_ISSUE;
              end else begin
                result       <= '0;
                illegal_op   <= 1'b1;
                result_valid <= 1'b1;
                state        <= S_DONE;
              end
            end
          end
          S_ISSUE: begin
            wd_cnt <= '0;
            state  <= S_WAIT;
          end
          S_WAIT: begin
            if (unit_ok) begin
              result       <= unit_c;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
              timeout_q    <= 1'b1;
              result       <= '1;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else begin
              wd_cnt <= wd_cnt + WDW'(1);
            end
          end
          S_DONE: begin
            if (stage_advance) begin
              result_valid <= 1'b0;
              illegal_op   <= 1'b0;
              state        <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Execute-stage initiator for the iterative multiply/divide unit. It accepts one mult/div request from the execute stage and latches the operands. It then launches the unit with a one-cycle start, holds the operands stable, and waits for the unit's done indication. It captures the result and holds it until the pipeline advances, stalling the pipeline while the operation is outstanding and cancelling cleanly on flush.

Parameters:
- XLEN, 64, operand/result width.
- TIMEOUT, 127, maximum WAIT cycles before the watchdog error fires.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  execute stage holds a mult/div instruction.
- req_op  input  4  op code: 0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10-15 illegal.
- req_a  input  XLEN  operand a.
- req_b  input  XLEN  operand b.
- stage_advance  input  1  downstream accepts the execute-stage result this cycle.
- flush  input  1  kill the in-flight instruction.
- stall  output  1  hold the execute stage.
- result  output  XLEN  captured result, valid when result_valid=1.
- result_valid  output  1  result available (state DONE).
- illegal_op  output  1  current result came from an illegal op code.
- timeout_err  output  1  sticky watchdog error.
- unit_valid  output  1  one-cycle start to the unit.
- unit_op  output  4  latched op code to the unit.
- unit_a  output  XLEN  latched operand a to the unit.
- unit_b  output  XLEN  latched operand b to the unit.
- unit_flush  output  1  cancel to the unit.
- unit_ok  input  1  unit done/idle (high when unit's next state is idle).
- unit_c  input  XLEN  unit result.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including unit_a/unit_b/unit_op registers.
  - timeout_err cleared.
  - Watchdog counter 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_valid & ~flush and req_op ≤ 9: latch op/a/b, go ISSUE.
  - If req_valid & ~flush and req_op ≥ 10: result=0, illegal_op=1, go DONE; the unit is never started.
- ISSUE (exactly one cycle):
  - unit_valid=1.
  - unit_ok is ignored.
  - Go WAIT; watchdog loads 0.
- WAIT:
  - unit_valid=0, operands held.
  - Watchdog increments each cycle.
  - On unit_ok=1: capture unit_c into result, go DONE.
  - If the watchdog reaches TIMEOUT without unit_ok:
    - Set timeout_err (sticky until reset) and pulse unit_flush one cycle.
    - result = all ones, go DONE.
- DONE:
  - result_valid=1; result and illegal_op are held.
  - On stage_advance: go IDLE and clear result_valid/illegal_op.
  - A new request is accepted no earlier than the following cycle, i.e. no re-issue of the completed instruction.
- stall = req_valid & ~result_valid & ~flush (combinational).
- unit_op, unit_a and unit_b change only on the IDLE→ISSUE transition.
- Latency: with a unit that raises unit_ok in cycle T+N, where T is the ISSUE cycle:
  - result_valid rises at T+N+1.
  - stall falls in the same cycle result_valid rises.
- Flush:
  - In any state: go IDLE next cycle and drop result/result_valid/illegal_op.
  - unit_flush=1 in the flush cycle if the state is ISSUE or WAIT.
  - flush has priority over req_valid, unit_ok and stage_advance arriving in the same cycle.
- Reset mid-operation: identical to flush, except unit_flush is not driven; the unit has its own reset.
- result_valid and unit_valid are never high together.

Test Plan:
- MUL, a=3, b=5, model unit with ok 2 cycles after issue:
  - unit_valid high 1 cycle.
  - stall high 3 cycles.
  - result=15 and result_valid at issue+3.
  - stage_advance then returns to IDLE.
- DIVU, a=100, b=7, ok after 65 cycles; unit_a/unit_b change mid-WAIT on the req_* inputs → unit operands stay 100/7; result=14.
- stage_advance held low for 5 cycles in DONE → result and result_valid held; no second unit_valid pulse; next request accepted the cycle after stage_advance.
- Flush in WAIT cycle 10:
  - unit_flush pulse in that cycle.
  - IDLE next cycle, result_valid never rises.
  - A simultaneous unit_ok is ignored.
- req_op=12 → no unit_valid; result=0, illegal_op=1, result_valid the next cycle.
- Unit never raises ok, TIMEOUT=127:
  - timeout_err and unit_flush at WAIT cycle 127.
  - result=all ones.
  - timeout_err remains set until reset.
